// File: rtl/sat_counter_branch_predictor.sv
// sat_counter_branch_predictor: table of saturating counters predicting branch direction,
// bimodal or gshare indexed, with forwarding of same-cycle updates and a mispredict counter.
module sat_counter_branch_predictor #(
    parameter int INDEX_BITS = 4,
    parameter int CTR_BITS   = 2,
    parameter int HIST_BITS  = 0,
    parameter int STAT_BITS  = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Lookup_Valid,
    input  logic [0:31]           Lookup_PC,
    output logic                  Pred_Valid,
    output logic                  Prediction,
    output logic [0:INDEX_BITS-1] Pred_Index,
    input  logic                  Update_Valid,
    input  logic [0:INDEX_BITS-1] Update_Index,
    input  logic                  Update_Taken,
    input  logic                  Update_Mispredict,
    output logic [0:STAT_BITS-1]  Mispredict_Count
);
    localparam int DEPTH = 1 << INDEX_BITS;
    localparam int GW = HIST_BITS > 0 ? HIST_BITS : 1;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

    logic [CTR_BITS-1:0]   ctr_q [DEPTH];
    logic [CTR_BITS-1:0]   ctr_d [DEPTH];
    logic [CTR_BITS-1:0]   cur;
    logic [GW-1:0]         ghr_q, ghr_d;
    logic [INDEX_BITS-1:0] idx, upd_idx;
    logic [INDEX_BITS-1:0] pred_index_q, pred_index_d;
    logic                  pred_valid_q, pred_valid_d;
    logic                  prediction_q, prediction_d;
    logic [STAT_BITS-1:0]  mis_q, mis_d;
    logic                  unused_pc;

    assign unused_pc = ^Lookup_PC[0:31-INDEX_BITS];

    always_comb begin
        upd_idx = Update_Index;
        // ghr_q stays zero in bimodal mode, so the XOR is a no-op there
        idx = Lookup_PC[32-INDEX_BITS:31] ^ INDEX_BITS'(ghr_q);
        for (int i = 0; i < DEPTH; i++) ctr_d[i] = ctr_q[i];
        cur = ctr_q[upd_idx];
        if (Update_Valid)
            ctr_d[upd_idx] = Update_Taken ? (cur == CTR_MAX ? cur : cur + CTR_BITS'(1))
                                          : (cur == '0 ? cur : cur - CTR_BITS'(1));
        ghr_d = (HIST_BITS > 0 && Update_Valid) ? (ghr_q << 1) | GW'(Update_Taken) : ghr_q;
        mis_d = (Update_Valid && Update_Mispredict && mis_q != '1) ? mis_q + STAT_BITS'(1) : mis_q;
        pred_valid_d = Lookup_Valid;
        // reading ctr_d forwards a same-cycle update to the lookup
        prediction_d = Lookup_Valid ? ctr_d[idx][CTR_BITS-1] : prediction_q;
        pred_index_d = Lookup_Valid ? idx : pred_index_q;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_INIT;
            ghr_q        <= '0;
            mis_q        <= '0;
            pred_valid_q <= 1'b0;
            prediction_q <= 1'b0;
            pred_index_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ctr_q[i] <= ctr_d[i];
            ghr_q        <= ghr_d;
            mis_q        <= mis_d;
            pred_valid_q <= pred_valid_d;
            prediction_q <= prediction_d;
            pred_index_q <= pred_index_d;
        end
    end

    assign Pred_Valid       = pred_valid_q;
    assign Prediction       = prediction_q;
    assign Pred_Index       = pred_index_q;
    assign Mispredict_Count = mis_q;
endmodule

// File: tb/tb_sat_counter_branch_predictor.sv
// tb_sat_counter_branch_predictor: bimodal and gshare instances driven together, checked
// against directed vectors and an integer-level reference model.
module tb_sat_counter_branch_predictor;
    logic        Clock, Reset, lv, uv, ut, um;
    logic [31:0] pc;
    logic [3:0]  ui;
    logic        pv0, pr0, pv1, pr1;
    logic [3:0]  pi0, pi1;
    logic [15:0] mc0;
    logic [1:0]  mc1;

    int n_vec = 0, n_bad = 0;
    int ctr [2][16];
    int ghr [2], mis [2], e_pv [2], e_pr [2], e_pi [2];

    typedef struct {
        bit r, l; int p; bit v; int i; bit t, m;
        int pv, pr, pi, mc;
    } vec_t;
    vec_t tbl [15];

    sat_counter_branch_predictor u0 (
        .Clock(Clock), .Reset(Reset), .Lookup_Valid(lv), .Lookup_PC(pc),
        .Pred_Valid(pv0), .Prediction(pr0), .Pred_Index(pi0),
        .Update_Valid(uv), .Update_Index(ui), .Update_Taken(ut),
        .Update_Mispredict(um), .Mispredict_Count(mc0));

    sat_counter_branch_predictor #(.INDEX_BITS(4), .CTR_BITS(2), .HIST_BITS(4), .STAT_BITS(2)) u1 (
        .Clock(Clock), .Reset(Reset), .Lookup_Valid(lv), .Lookup_PC(pc),
        .Pred_Valid(pv1), .Prediction(pr1), .Pred_Index(pi1),
        .Update_Valid(uv), .Update_Index(ui), .Update_Taken(ut),
        .Update_Mispredict(um), .Mispredict_Count(mc1));

    initial begin
        Clock = 0;
        forever #5 Clock = ~Clock;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model();
        for (int k = 0; k < 2; k++) begin
            int idx, smax;
            smax = k ? 3 : 65535;
            if (Reset) begin
                for (int j = 0; j < 16; j++) ctr[k][j] = 2;
                ghr[k] = 0; mis[k] = 0; e_pv[k] = 0; e_pr[k] = 0; e_pi[k] = 0;
            end else begin
                idx = (int'(pc) & 15) ^ ghr[k];
                if (uv) begin
                    if (ut) ctr[k][ui] = ctr[k][ui] < 3 ? ctr[k][ui] + 1 : 3;
                    else    ctr[k][ui] = ctr[k][ui] > 0 ? ctr[k][ui] - 1 : 0;
                    if (um) mis[k] = mis[k] < smax ? mis[k] + 1 : smax;
                    if (k == 1) ghr[k] = ((ghr[k] * 2) + int'(ut)) % 16;
                end
                e_pv[k] = int'(lv);
                if (lv) begin
                    e_pr[k] = ctr[k][idx] >= 2 ? 1 : 0;
                    e_pi[k] = idx;
                end
            end
        end
    endtask

    task automatic step(input bit r, l, input int p, input bit v, input int i, input bit t, m);
        Reset = r; lv = l; pc = p; uv = v; ui = i[3:0]; ut = t; um = m;
        @(posedge Clock);
        model();
        #1;
        chk("m0_pv", pv0, e_pv[0]); chk("m0_pr", pr0, e_pr[0]);
        chk("m0_pi", pi0, e_pi[0]); chk("m0_mc", mc0, mis[0]);
        chk("m1_pv", pv1, e_pv[1]); chk("m1_pr", pr1, e_pr[1]);
        chk("m1_pi", pi1, e_pi[1]); chk("m1_mc", mc1, mis[1]);
    endtask

    initial begin
        bit hist [4];
        hist = '{1, 1, 0, 1};
        Reset = 1; lv = 0; pc = 0; uv = 0; ui = 0; ut = 0; um = 0;
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0};
        tbl[1]  = '{0, 1, 7, 0, 0, 0, 0,   1, 1, 7, 0};
        tbl[2]  = '{0, 0, 0, 1, 3, 0, 1,   0, 1, 7, 1};
        tbl[3]  = '{0, 0, 0, 1, 3, 0, 1,   0, 1, 7, 2};
        tbl[4]  = '{0, 1, 3, 0, 0, 0, 0,   1, 0, 3, 2};
        tbl[5]  = '{0, 1, 3, 1, 3, 1, 0,   1, 0, 3, 2};
        tbl[6]  = '{0, 1, 3, 1, 3, 1, 0,   1, 1, 3, 2};
        tbl[7]  = '{0, 0, 0, 1, 5, 1, 0,   0, 1, 3, 2};
        tbl[8]  = '{0, 0, 0, 1, 5, 1, 0,   0, 1, 3, 2};
        tbl[9]  = '{0, 0, 0, 1, 5, 1, 0,   0, 1, 3, 2};
        tbl[10] = '{0, 0, 0, 1, 5, 1, 0,   0, 1, 3, 2};
        tbl[11] = '{0, 0, 0, 1, 5, 1, 0,   0, 1, 3, 2};
        tbl[12] = '{0, 1, 5, 1, 5, 0, 0,   1, 1, 5, 2};
        tbl[13] = '{0, 1, 9, 1, 9, 0, 0,   1, 0, 9, 2};
        tbl[14] = '{0, 0, 0, 0, 0, 0, 1,   0, 0, 9, 2};
        for (int j = 0; j < 15; j++) begin
            step(tbl[j].r, tbl[j].l, tbl[j].p, tbl[j].v, tbl[j].i, tbl[j].t, tbl[j].m);
            chk($sformatf("tbl%0d_pv", j), pv0, tbl[j].pv);
            chk($sformatf("tbl%0d_pr", j), pr0, tbl[j].pr);
            chk($sformatf("tbl%0d_pi", j), pi0, tbl[j].pi);
            chk($sformatf("tbl%0d_mc", j), mc0, tbl[j].mc);
        end
        // gshare history and saturating 2-bit mispredict counter
        step(1, 0, 0, 0, 0, 0, 0);
        for (int j = 0; j < 4; j++) begin
            step(0, 0, 0, 1, 0, hist[j], 1);
            chk($sformatf("stat_mc%0d", j), mc1, j < 3 ? j + 1 : 3);
        end
        step(0, 1, 2, 0, 0, 0, 0);
        chk("gshare_idx", pi1, 15);
        chk("bimodal_idx", pi0, 2);
        step(0, 0, 0, 1, 1, 1, 1);
        step(1, 1, 0, 1, 1, 1, 1);
        chk("rst_mc1", mc1, 0);
        chk("rst_mc0", mc0, 0);
        chk("rst_pv", pv0, 0);
        step(0, 1, 6, 1, 6, 0, 0);
        chk("rst_ctr0", pr0, 0);
        chk("rst_ctr1", pr1, 0);
        chk("rst_idx1", pi1, 6);
        for (int j = 0; j < 600; j++)
            step($urandom_range(63) == 0, $urandom_range(1), $urandom, $urandom_range(3) != 0,
                 $urandom_range(15), $urandom_range(1), $urandom_range(1));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
